multi_cycle_ctrl: RTL and testbench

Multi-cycle MIPS control unit and the sequential successor to the single-cycle op/funct decoder. It sequences each instruction through IF/ID/EX/MEM/WB and issues one-cycle register, PC and memory enables. It supports a ready-handshake memory with a wait timeout. It sits between the IR/ALU datapath and a shared instruction/data memory.

---
 rtl/mc_ctrl_pkg.sv | 87 ++++++++
 rtl/multi_cycle_ctrl_if.sv | 42 ++++
 rtl/mc_decode.sv | 79 +++++++
 rtl/multi_cycle_ctrl.sv | 125 ++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared opcode/funct, ALU, state and mux-select encodings for the multi-cycle MIPS controller
// Contents: instruction field codes, ALU_OP codes, FSM state enum, PC_s/w_r_s/wr_data_s encodings,
//           decoded instruction class struct and the R-type funct -> ALU_OP helper.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    localparam logic [1:0] PCS_PC4 = 2'b00;
    localparam logic [1:0] PCS_RS  = 2'b01;
    localparam logic [1:0] PCS_BR  = 2'b10;
    localparam logic [1:0] PCS_JMP = 2'b11;

    localparam logic [1:0] WRS_RD = 2'b00;
    localparam logic [1:0] WRS_RT = 2'b01;
    localparam logic [1:0] WRS_RA = 2'b10;

    localparam logic [1:0] WDS_ALU = 2'b00;
    localparam logic [1:0] WDS_MDR = 2'b01;
    localparam logic [1:0] WDS_PC  = 2'b10;

    typedef struct packed {
        logic r_alu;
        logic i_alu;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jr;
        logic jal;
        logic illegal;
    } iclass_t;

    // {supported, ALU_OP} for an R-type funct; jr is not an ALU op and reports unsupported here
    function automatic logic [3:0] rfunct_alu(input logic [5:0] f);
        case (f)
            FN_ADD:  return {1'b1, ALU_ADD};
            FN_SUB:  return {1'b1, ALU_SUB};
            FN_AND:  return {1'b1, ALU_AND};
            FN_OR:   return {1'b1, ALU_OR};
            FN_XOR:  return {1'b1, ALU_XOR};
            FN_NOR:  return {1'b1, ALU_NOR};
            FN_SLTU: return {1'b1, ALU_SLTU};
            FN_SLLV: return {1'b1, ALU_SLLV};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: controller <-> datapath/memory bundle
// Inputs to the controller: op_code, funct (IR fields), ZF (ALU zero), mem_ready (memory completion).
// Outputs: register/PC/memory enables, datapath mux selects, ALU_OP, state and status pulses.
interface multi_cycle_ctrl_if;

    logic [5:0] op_code;
    logic [5:0] funct;
    logic       ZF;
    logic       mem_ready;
    logic       PC_Write;
    logic       IR_Write;
    logic       IorD;
    logic       Mem_Read;
    logic       Mem_Write;
    logic       MDR_Write;
    logic       Write_Reg;
    logic [2:0] ALU_OP;
    logic [1:0] w_r_s;
    logic [1:0] wr_data_s;
    logic       imm_s;
    logic       rt_imm_s;
    logic [1:0] PC_s;
    logic [2:0] state;
    logic       instr_done;
    logic       illegal_instr;
    logic       err;

    modport master (
        input  op_code, funct, ZF, mem_ready,
        output PC_Write, IR_Write, IorD, Mem_Read, Mem_Write, MDR_Write, Write_Reg,
               ALU_OP, w_r_s, wr_data_s, imm_s, rt_imm_s, PC_s, state,
               instr_done, illegal_instr, err
    );

    modport slave (
        output op_code, funct, ZF, mem_ready,
        input  PC_Write, IR_Write, IorD, Mem_Read, Mem_Write, MDR_Write, Write_Reg,
               ALU_OP, w_r_s, wr_data_s, imm_s, rt_imm_s, PC_s, state,
               instr_done, illegal_instr, err
    );

endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational op_code/funct decoder for the multi-cycle controller
// Ports: i_op_code, i_funct -> o_alu_op, o_w_r_s, o_wr_data_s, o_imm_s, o_rt_imm_s,
//        o_pc_s (jump/branch target select), o_cls (instruction class flags incl. illegal)
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_op_code,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic [1:0] o_w_r_s,
    output logic [1:0] o_wr_data_s,
    output logic       o_imm_s,
    output logic       o_rt_imm_s,
    output logic [1:0] o_pc_s,
    output iclass_t    o_cls
);

    logic [3:0] w_rf;

    assign w_rf = rfunct_alu(i_funct);

    always_comb begin
        o_alu_op    = ALU_ADD;
        o_w_r_s     = WRS_RD;
        o_wr_data_s = WDS_ALU;
        o_imm_s     = 1'b0;
        o_rt_imm_s  = 1'b0;
        o_pc_s      = PCS_PC4;
        o_cls       = '0;
        case (i_op_code)
            OP_RTYPE: begin
                o_alu_op      = w_rf[2:0];
                o_cls.r_alu   = w_rf[3];
                o_cls.jr      = i_funct == FN_JR;
                o_cls.illegal = !w_rf[3] && i_funct != FN_JR;
                o_pc_s        = (i_funct == FN_JR) ? PCS_RS : PCS_PC4;
            end
            OP_ADDI, OP_ANDI, OP_XORI, OP_SLTIU: begin
                o_cls.i_alu = 1'b1;
                o_w_r_s     = WRS_RT;
                o_rt_imm_s  = 1'b1;
                o_imm_s     = i_op_code == OP_ADDI;
                o_alu_op    = (i_op_code == OP_ANDI) ? ALU_AND :
                              (i_op_code == OP_XORI) ? ALU_XOR :
                              (i_op_code == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
            end
            OP_LW: begin
                o_cls.lw    = 1'b1;
                o_imm_s     = 1'b1;
                o_rt_imm_s  = 1'b1;
                o_w_r_s     = WRS_RT;
                o_wr_data_s = WDS_MDR;
            end
            OP_SW: begin
                o_cls.sw   = 1'b1;
                o_imm_s    = 1'b1;
                o_rt_imm_s = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                o_cls.beq = i_op_code == OP_BEQ;
                o_cls.bne = i_op_code == OP_BNE;
                o_alu_op  = ALU_SUB;
                o_pc_s    = PCS_BR;
            end
            OP_J: begin
                o_cls.j = 1'b1;
                o_pc_s  = PCS_JMP;
            end
            OP_JAL: begin
                o_cls.jal   = 1'b1;
                o_w_r_s     = WRS_RA;
                o_wr_data_s = WDS_PC;
                o_pc_s      = PCS_JMP;
            end
            default: o_cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory ready handshake and wait timeout
// Ports: clk, rst (async, active-high); bus (multi_cycle_ctrl_if.master) carrying IR fields, ZF,
//        mem_ready in and all enables, selects, state, instr_done, illegal_instr, err out.
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int MAX_WAIT      = 15,
    parameter int WAIT_W        = 4
) (
    input logic                 clk,
    input logic                 rst,
    multi_cycle_ctrl_if.master  bus
);

    state_t            r_state, w_next;
    logic [WAIT_W-1:0] r_wait, w_wait;
    logic              r_err;
    logic              w_mem_done, w_tmo;
    logic              w_pcw, w_irw, w_iord, w_mr, w_mw, w_mdr, w_wr, w_done, w_ill;
    logic [2:0]        w_alu_op;
    logic [1:0]        w_w_r_s, w_wr_data_s, w_pc_s;
    logic              w_imm_s, w_rt_imm_s;
    iclass_t           w_cls;

    mc_decode u_decode (
        .i_op_code   (bus.op_code),
        .i_funct     (bus.funct),
        .o_alu_op    (w_alu_op),
        .o_w_r_s     (w_w_r_s),
        .o_wr_data_s (w_wr_data_s),
        .o_imm_s     (w_imm_s),
        .o_rt_imm_s  (w_rt_imm_s),
        .o_pc_s      (w_pc_s),
        .o_cls       (w_cls)
    );

    assign w_mem_done = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    // this not-ready cycle would be the MAX_WAIT-th in a row; a completion here still wins
    assign w_tmo = !w_mem_done && ((r_wait + WAIT_W'(1)) == WAIT_W'(MAX_WAIT));

    always_comb begin
        w_next = r_state;
        w_wait = r_wait;
        w_pcw  = 1'b0;
        w_irw  = 1'b0;
        w_iord = 1'b0;
        w_mr   = 1'b0;
        w_mw   = 1'b0;
        w_mdr  = 1'b0;
        w_wr   = 1'b0;
        w_done = 1'b0;
        w_ill  = 1'b0;
        case (r_state)
            S_IF: begin
                w_mr   = 1'b1;
                w_irw  = w_mem_done;
                w_pcw  = w_mem_done;
                w_wait = w_mem_done ? '0 : r_wait + WAIT_W'(1);
                w_next = w_mem_done ? S_ID : (w_tmo ? S_ERR : S_IF);
            end
            S_ID: begin
                w_ill  = w_cls.illegal;
                w_pcw  = w_cls.j | w_cls.jr;
                w_done = w_cls.j | w_cls.jr;
                w_next = (w_cls.illegal | w_cls.j | w_cls.jr) ? S_IF : S_EX;
            end
            S_EX: begin
                w_pcw  = (w_cls.beq & bus.ZF) | (w_cls.bne & ~bus.ZF) | w_cls.jal;
                w_wr   = w_cls.jal;
                w_done = w_cls.beq | w_cls.bne | w_cls.jal;
                w_next = (w_cls.lw | w_cls.sw) ? S_MEM : (w_cls.r_alu | w_cls.i_alu) ? S_WB : S_IF;
            end
            S_MEM: begin
                w_iord = 1'b1;
                w_mr   = w_cls.lw;
                w_mw   = w_cls.sw;
                w_mdr  = w_mem_done & w_cls.lw;
                w_done = w_mem_done & w_cls.sw;
                w_wait = w_mem_done ? '0 : r_wait + WAIT_W'(1);
                w_next = w_mem_done ? (w_cls.lw ? S_WB : S_IF) : (w_tmo ? S_ERR : S_MEM);
            end
            S_WB: begin
                w_wr   = 1'b1;
                w_done = 1'b1;
                w_next = S_IF;
            end
            S_ERR: w_next = S_ERR;
            default: w_next = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IF;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait;
            r_err   <= r_err | (w_next == S_ERR);
        end
    end

    // reset forces state to IF asynchronously, so enables are masked to keep IF's read request quiet
    assign bus.PC_Write      = w_pcw & ~rst;
    assign bus.IR_Write      = w_irw & ~rst;
    assign bus.IorD          = w_iord;
    assign bus.Mem_Read      = w_mr & ~rst;
    assign bus.Mem_Write     = w_mw & ~rst;
    assign bus.MDR_Write     = w_mdr & ~rst;
    assign bus.Write_Reg     = w_wr & ~rst;
    assign bus.instr_done    = w_done & ~rst;
    assign bus.illegal_instr = w_ill & ~rst;
    assign bus.ALU_OP        = w_alu_op;
    assign bus.w_r_s         = w_w_r_s;
    assign bus.wr_data_s     = w_wr_data_s;
    assign bus.imm_s         = w_imm_s;
    assign bus.rt_imm_s      = w_rt_imm_s;
    // the IR still holds the previous instruction during IF, so fetch always selects PC+4
    assign bus.PC_s          = (r_state == S_IF) ? PCS_PC4 : w_pc_s;
    assign bus.state         = r_state;
    assign bus.err           = r_err;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed self-checking bench; builds each instruction's expected cycle trace and compares every cycle
module tb_multi_cycle_ctrl;

    localparam int MAXW = 15;
    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_BNE = 5, C_J = 6, C_JR = 7, C_JAL = 8, C_ILL = 9;

    typedef struct packed {
        logic [2:0] st;
        logic       rdy;
        logic       zf;
        logic       pcw, irw, iord, mr, mw, mdr, wr, done, ill, err;
        logic [1:0] pcs;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus ();
    multi_cycle_ctrl #(.MEM_HANDSHAKE(1'b1), .MAX_WAIT(MAXW), .WAIT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    cyc_t exp_c;
    bit exp_valid = 0;
    int exp_idx = 0;
    int n_cyc = 0;
    bit first = 0;
    logic [5:0] cur_op, cur_fn;
    logic cur_zf;
    logic [31:0] lg_wr, lg_pcw, lg_mr, lg_mw, lg_iord, lg_mdr, lg_done, lg_ill, lg_err;
    logic [2:0] lg_st [32];
    logic [2:0] lg_alu [32];
    logic [1:0] lg_wrs [32];
    logic [1:0] lg_wds [32];
    logic [1:0] lg_pcs [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    // reference decode straight from the instruction table: {ALU_OP, w_r_s, wr_data_s, imm_s, rt_imm_s}
    function automatic logic [8:0] ref_sel(input logic [5:0] op, input logic [5:0] f);
        logic [2:0] a;
        logic [1:0] ws, wd;
        logic im, ri;
        a = 3'b100; ws = 2'b00; wd = 2'b00; im = 1'b0; ri = 1'b0;
        case (op)
            6'b000000: case (f)
                6'b100010: a = 3'b101;
                6'b100100: a = 3'b000;
                6'b100101: a = 3'b001;
                6'b100110: a = 3'b010;
                6'b100111: a = 3'b011;
                6'b101011: a = 3'b110;
                6'b000100: a = 3'b111;
                default: a = 3'b100;
            endcase
            6'b001000: begin im = 1'b1; ws = 2'b01; ri = 1'b1; end
            6'b001100: begin a = 3'b000; ws = 2'b01; ri = 1'b1; end
            6'b001110: begin a = 3'b010; ws = 2'b01; ri = 1'b1; end
            6'b001011: begin a = 3'b110; ws = 2'b01; ri = 1'b1; end
            6'b100011: begin im = 1'b1; ri = 1'b1; wd = 2'b01; ws = 2'b01; end
            6'b101011: begin im = 1'b1; ri = 1'b1; end
            6'b000100, 6'b000101: a = 3'b101;
            6'b000011: begin ws = 2'b10; wd = 2'b10; end
            default: a = 3'b100;
        endcase
        return {a, ws, wd, im, ri};
    endfunction

    function automatic int klass(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'b000000: return (f == 6'b001000) ? C_JR :
                              (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                         6'b100110, 6'b100111, 6'b101011, 6'b000100}) ? C_R : C_ILL;
            6'b001000, 6'b001100, 6'b001110, 6'b001011: return C_I;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000101: return C_BNE;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    // one expected cycle: inputs applied just after the edge that starts it
    task automatic emit(input cyc_t c);
        if (!first) begin
            @(posedge clk);
            #1;
        end
        first = 0;
        bus.op_code = cur_op;
        bus.funct = cur_fn;
        bus.ZF = cur_zf;
        bus.mem_ready = c.rdy;
        exp_c = c;
        exp_idx = n_cyc;
        exp_valid = 1;
        n_cyc++;
    endtask

    // mem_wait < 0 stops after the first not-ready MEM cycle; if_wait >= MAXW models a fetch timeout
    task automatic run(input logic [5:0] op, input logic [5:0] f, input logic zf, input int if_wait, input int mem_wait);
        int k;
        cyc_t c;
        k = klass(op, f);
        cur_op = op; cur_fn = f; cur_zf = zf;
        n_cyc = 0;
        for (int i = 0; i <= if_wait && i < MAXW; i++) begin
            c = '0; c.st = 3'd0; c.mr = 1; c.rdy = (i == if_wait); c.irw = c.rdy; c.pcw = c.rdy;
            emit(c);
        end
        if (if_wait >= MAXW) begin
            repeat (3) begin
                c = '0; c.st = 3'd7; c.err = 1;
                emit(c);
            end
            return;
        end
        c = '0; c.st = 3'd1;
        c.ill = (k == C_ILL);
        c.pcw = (k == C_J) || (k == C_JR);
        c.done = c.pcw;
        c.pcs = (k == C_J) ? 2'b11 : 2'b01;
        emit(c);
        if (k == C_ILL || k == C_J || k == C_JR) return;
        c = '0; c.st = 3'd2; c.zf = zf;
        c.pcw = (k == C_BEQ && zf) || (k == C_BNE && !zf) || (k == C_JAL);
        c.wr = (k == C_JAL);
        c.done = (k == C_BEQ) || (k == C_BNE) || (k == C_JAL);
        c.pcs = (k == C_JAL) ? 2'b11 : 2'b10;
        emit(c);
        if (c.done) return;
        if (k == C_LW || k == C_SW) begin
            for (int i = 0; i <= (mem_wait < 0 ? 0 : mem_wait); i++) begin
                c = '0; c.st = 3'd3; c.iord = 1; c.mr = (k == C_LW); c.mw = (k == C_SW);
                c.rdy = (mem_wait >= 0) && (i == mem_wait);
                c.mdr = c.rdy && (k == C_LW);
                c.done = c.rdy && (k == C_SW);
                emit(c);
            end
            if (k == C_SW || mem_wait < 0) return;
        end
        c = '0; c.st = 3'd4; c.wr = 1; c.done = 1;
        emit(c);
    endtask

    function automatic logic [9:0] dut_en();
        return {bus.PC_Write, bus.IR_Write, bus.IorD, bus.Mem_Read, bus.Mem_Write,
                bus.MDR_Write, bus.Write_Reg, bus.instr_done, bus.illegal_instr, bus.err};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("state", 32'(bus.state), 32'(exp_c.st));
            chk("enables", 32'(dut_en()), 32'({exp_c.pcw, exp_c.irw, exp_c.iord, exp_c.mr, exp_c.mw,
                                               exp_c.mdr, exp_c.wr, exp_c.done, exp_c.ill, exp_c.err}));
            if (exp_c.pcw) chk("PC_s", 32'(bus.PC_s), 32'(exp_c.pcs));
            chk("selects", 32'({bus.ALU_OP, bus.w_r_s, bus.wr_data_s, bus.imm_s, bus.rt_imm_s}),
                32'(ref_sel(bus.op_code, bus.funct)));
            if (exp_idx == 0) begin
                lg_wr = '0; lg_pcw = '0; lg_mr = '0; lg_mw = '0; lg_iord = '0;
                lg_mdr = '0; lg_done = '0; lg_ill = '0; lg_err = '0;
            end
            lg_wr[exp_idx] = bus.Write_Reg;
            lg_pcw[exp_idx] = bus.PC_Write;
            lg_mr[exp_idx] = bus.Mem_Read;
            lg_mw[exp_idx] = bus.Mem_Write;
            lg_iord[exp_idx] = bus.IorD;
            lg_mdr[exp_idx] = bus.MDR_Write;
            lg_done[exp_idx] = bus.instr_done;
            lg_ill[exp_idx] = bus.illegal_instr;
            lg_err[exp_idx] = bus.err;
            lg_st[exp_idx] = bus.state;
            lg_alu[exp_idx] = bus.ALU_OP;
            lg_wrs[exp_idx] = bus.w_r_s;
            lg_wds[exp_idx] = bus.wr_data_s;
            lg_pcs[exp_idx] = bus.PC_s;
        end
    end

    logic [5:0] t_op [18] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'b001000, 6'b001100,
                              6'b001110, 6'b001011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'h00, 6'h00, 6'b100011};
    logic [5:0] t_fn [18] = '{6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101011, 6'b000100, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'b001000, 6'b000001, 6'h00};
    logic t_zf [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int t_iw [18] = '{1, 0, 0, 0, 0, 2, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int t_mw [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0};

    initial begin
        bus.op_code = 6'h00; bus.funct = 6'h00; bus.ZF = 1'b0; bus.mem_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_enables", 32'(dut_en()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        first = 1;

        run(6'h00, 6'b100000, 1'b0, 0, 0);
        @(negedge clk); #1;
        chk("add_cpi", 32'(n_cyc), 32'd4);
        chk("add_states", 32'({lg_st[0], lg_st[1], lg_st[2], lg_st[3]}), 32'({3'd0, 3'd1, 3'd2, 3'd4}));
        chk("add_alu_ex", 32'(lg_alu[2]), 32'(3'b100));
        chk("add_wr_only_wb", 32'(lg_wr[3:0]), 32'(4'b1000));
        chk("add_wrs_wb", 32'(lg_wrs[3]), 32'(2'b00));
        chk("add_done_once", 32'(lg_done[3:0]), 32'(4'b1000));

        run(6'b100011, 6'h00, 1'b0, 0, 3);
        @(negedge clk); #1;
        chk("lw_cpi", 32'(n_cyc), 32'd8);
        chk("lw_mem_read", 32'(lg_mr[7:0]), 32'(8'h79));
        chk("lw_iord", 32'(lg_iord[7:0]), 32'(8'h78));
        chk("lw_mdr", 32'(lg_mdr[7:0]), 32'(8'h40));
        chk("lw_wr", 32'(lg_wr[7:0]), 32'(8'h80));
        chk("lw_sel_wb", 32'({lg_wds[7], lg_wrs[7]}), 32'(4'b0101));

        run(6'b000100, 6'h00, 1'b1, 0, 0);
        @(negedge clk); #1;
        chk("beq_cpi", 32'(n_cyc), 32'd3);
        chk("beq_pcw", 32'(lg_pcw[2:0]), 32'(3'b101));
        chk("beq_pcs", 32'(lg_pcs[2]), 32'(2'b10));

        run(6'b000101, 6'h00, 1'b1, 0, 0);
        @(negedge clk); #1;
        chk("bne_pcw", 32'(lg_pcw[2:0]), 32'(3'b001));
        chk("bne_done", 32'(lg_done[2:0]), 32'(3'b100));

        run(6'b000011, 6'h00, 1'b0, 0, 0);
        @(negedge clk); #1;
        chk("jal_cpi", 32'(n_cyc), 32'd3);
        chk("jal_wr", 32'(lg_wr[2:0]), 32'(3'b100));
        chk("jal_sel", 32'({lg_wrs[2], lg_wds[2], lg_pcs[2]}), 32'(6'b101011));
        chk("jal_pcw", 32'(lg_pcw[2:0]), 32'(3'b101));

        run(6'b111111, 6'h00, 1'b0, 0, 0);
        @(negedge clk); #1;
        chk("ill_cpi", 32'(n_cyc), 32'd2);
        chk("ill_pulse", 32'(lg_ill[1:0]), 32'(2'b10));
        chk("ill_quiet", 32'({lg_wr[1:0], lg_pcw[1:0], lg_done[1:0]}), 32'(6'b000100));

        for (int i = 0; i < 18; i++) run(t_op[i], t_fn[i], t_zf[i], t_iw[i], t_mw[i]);

        run(6'b101011, 6'h00, 1'b0, 0, -1);
        @(negedge clk); #1;
        chk("sw_mem_write", 32'(lg_mw[3]), 32'd1);
        exp_valid = 0;
        rst = 1'b1;
        #1;
        chk("rst_mid_sw_mw", 32'(bus.Mem_Write), 32'd0);
        chk("rst_mid_sw_state", 32'(bus.state), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_read", 32'({bus.state, bus.Mem_Read}), 32'({3'd0, 1'b1}));
        first = 1;
        run(6'h00, 6'b100101, 1'b0, 0, 0);

        run(6'h00, 6'b100000, 1'b0, 14, 0);
        @(negedge clk); #1;
        chk("late_ready_id", 32'(lg_st[15]), 32'd1);

        run(6'h00, 6'b100000, 1'b0, MAXW, 0);
        @(negedge clk); #1;
        chk("tmo_state", 32'(lg_st[15]), 32'd7);
        chk("tmo_err", 32'(lg_err[17:14]), 32'(4'b1110));
        repeat (4) @(negedge clk);
        #1;
        chk("err_sticky", 32'({bus.state, bus.err}), 32'({3'd7, 1'b1}));
        exp_valid = 0;
        rst = 1'b1;
        #1;
        chk("err_clear", 32'({bus.state, bus.err}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        first = 1;
        run(6'b100011, 6'h00, 1'b0, 1, 1);
        @(negedge clk); #1;
        exp_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
